// File: rtl/uart_tx_if.sv
// Handshake bundle between the TX FIFO read side / baud generator and the UART transmitter.
// Ports: s_tick (16x baud enable), tx_start + din (request and word), tx (serial line),
//        tx_busy (frame in progress), tx_done_tick (one-cycle end-of-frame pulse).
interface uart_tx_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;

    modport master (
        output s_tick, tx_start, din,
        input  tx, tx_busy, tx_done_tick
    );

    modport slave (
        input  s_tick, tx_start, din,
        output tx, tx_busy, tx_done_tick
    );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DBIT data bits LSB-first, optional even parity, stop period.
// Ports: clk, rst_n (async active-low), bus (uart_tx_if.slave: s_tick, tx_start, din, tx, tx_busy, tx_done_tick).
// Optional parity bit enabled by defining UART_TX_PARITY_EN; tx is registered, tx_start ignored while busy.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);

    // Tick counter must hold both 15 (per-bit) and SB_TICK-1 (stop period).
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_LAST    = SW'(15);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic [SW-1:0]   s_reg;
    logic [NW-1:0]   n_reg;
    logic [DBIT-1:0] b_reg;
    logic            tx_reg;
    logic            busy_reg;
    logic            done_reg;
`ifdef UART_TX_PARITY_EN
    logic            par_reg;
`endif

    // tx_reg/busy_reg are loaded with the value belonging to the state being
    // entered, so the pin changes on the same edge as the state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_reg    <= '0;
            n_reg    <= '0;
            b_reg    <= '0;
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tx_start) begin
                        b_reg    <= bus.din;
                        s_reg    <= '0;
                        state    <= START;
                        tx_reg   <= 1'b0;
                        busy_reg <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        par_reg  <= ^bus.din;
`endif
                    end
                end
                START: begin
                    if (bus.s_tick) begin
                        if (s_reg == S_LAST) begin
                            s_reg  <= '0;
                            n_reg  <= '0;
                            state  <= DATA;
                            tx_reg <= b_reg[0];
                        end else begin
                            s_reg <= s_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (bus.s_tick) begin
                        if (s_reg == S_LAST) begin
                            s_reg <= '0;
                            b_reg <= b_reg >> 1;
                            if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                                state  <= PARITY;
                                tx_reg <= par_reg;
`else
                                state  <= STOP;
                                tx_reg <= 1'b1;
`endif
                            end else begin
                                n_reg  <= n_reg + 1'b1;
                                // Next bit is the one about to shift into b_reg[0].
                                tx_reg <= b_reg[1];
                            end
                        end else begin
                            s_reg <= s_reg + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bus.s_tick) begin
                        if (s_reg == S_LAST) begin
                            s_reg  <= '0;
                            state  <= STOP;
                            tx_reg <= 1'b1;
                        end else begin
                            s_reg <= s_reg + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (bus.s_tick) begin
                        if (s_reg == STOP_LAST) begin
                            s_reg    <= '0;
                            state    <= IDLE;
                            tx_reg   <= 1'b1;
                            busy_reg <= 1'b0;
                            done_reg <= 1'b1;
                        end else begin
                            s_reg <= s_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx           = tx_reg;
    assign bus.tx_busy      = busy_reg;
    assign bus.tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (SB_TICK 16 and 32) share stimulus; a tick-count frame model
// predicts tx/tx_busy/tx_done_tick every cycle, plus literal bit-sample and frame-length checks.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;
    localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            s_tick   = 1'b0;
    logic            tx_start = 1'b0;
    logic [DBIT-1:0] din      = '0;

    uart_tx_if #(.DBIT(DBIT)) if16 ();
    uart_tx_if #(.DBIT(DBIT)) if32 ();

    assign if16.s_tick = s_tick;
    assign if16.tx_start = tx_start;
    assign if16.din = din;
    assign if32.s_tick = s_tick;
    assign if32.tx_start = tx_start;
    assign if32.din = din;

    uart_tx #(.DBIT(DBIT), .SB_TICK(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    uart_tx #(.DBIT(DBIT), .SB_TICK(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    logic [1:0] o_tx, o_busy, o_done;
    assign o_tx   = {if32.tx, if16.tx};
    assign o_busy = {if32.tx_busy, if16.tx_busy};
    assign o_done = {if32.tx_done_tick, if16.tx_done_tick};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: frame = list of bits, each 16 ticks, stop SB ticks
    bit          m_act[2];
    bit          m_done[2];
    int          m_ticks[2];
    logic [15:0] m_frame[2];

    function automatic int total_ticks(input int d);
        return 16 * (1 + DBIT + PB) + ((d == 1) ? 32 : 16);
    endfunction

    function automatic logic exp_tx(input int d);
        int idx;
        if (!m_act[d]) return 1'b1;
        idx = m_ticks[d] / 16;
        if (idx <= DBIT + PB) return m_frame[d][idx];
        return 1'b1;
    endfunction

    task automatic model_step(input int d);
        if (!rst_n) begin
            m_act[d] = 1'b0;
            m_done[d] = 1'b0;
            m_ticks[d] = 0;
        end else begin
            m_done[d] = 1'b0;
            if (!m_act[d]) begin
                if (tx_start) begin
                    m_act[d] = 1'b1;
                    m_ticks[d] = 0;
                    m_frame[d] = {6'b0, ^din, din, 1'b0};
                end
            end else if (s_tick) begin
                m_ticks[d]++;
                if (m_ticks[d] == total_ticks(d)) begin
                    m_act[d] = 1'b0;
                    m_done[d] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- observations of the DUTs for literal checks
    int cyc = 0;
    int acc_edge[2];
    int done_edge[2];
    int gap[2];
    int n_acc[2];
    int n_done[2];
    bit prev_busy[2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            acc_edge[d] = 0; done_edge[d] = 0; gap[d] = 0;
            n_acc[d] = 0; n_done[d] = 0; prev_busy[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) model_step(d);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("tx%0d", d), o_tx[d], exp_tx(d));
                chk($sformatf("busy%0d", d), o_busy[d], m_act[d]);
                chk($sformatf("done%0d", d), o_done[d], m_done[d]);
                if (o_busy[d] && !prev_busy[d]) begin
                    gap[d] = cyc - done_edge[d];
                    acc_edge[d] = cyc;
                    n_acc[d]++;
                end
                prev_busy[d] = o_busy[d];
                if (o_done[d]) begin
                    done_edge[d] = cyc;
                    n_done[d]++;
                end
            end
        end
    end

    // ---------------- s_tick generator
    int tick_period = 4;
    int tcnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (tcnt >= tick_period - 1) begin
                tcnt = 0;
                s_tick = 1'b1;
            end else begin
                tcnt++;
                s_tick = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((m_act[0] || m_act[1]) && n < 6000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({nm, "_timeout"}, (n >= 6000), 0);
    endtask

    // Accept on an edge that also carries s_tick, so every bit is exactly 64 clk.
    task automatic send_aligned(input logic [DBIT-1:0] v);
        int n;
        wait_idle("pre_send");
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!s_tick && n < 20);
        din = v;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    // Called at acceptance edge + 1: samples the 16-stop instance mid-bit.
    task automatic sample_frame(input logic [15:0] exp, input int nb, input string nm);
        repeat (32) @(posedge clk);
        #2;
        chk($sformatf("%s_bit0", nm), o_tx[0], exp[0]);
        for (int i = 1; i < nb; i++) begin
            repeat (64) @(posedge clk);
            #2;
            chk($sformatf("%s_bit%0d", nm, i), o_tx[0], exp[i]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] exp_bits;
    int b0, b1, d0, d1;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx16", o_tx[0], 1'b1);
        chk("rst_busy16", o_busy[0], 1'b0);
        chk("rst_done16", o_done[0], 1'b0);
        chk("rst_tx32", o_tx[1], 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Single frame 0xA5, s_tick every 4 clk
        tick_period = 4;
        d0 = n_done[0];
        send_aligned(8'hA5);
`ifdef UART_TX_PARITY_EN
        exp_bits = 16'h054A;
`else
        exp_bits = 16'h034A;
`endif
        sample_frame(exp_bits, 10 + PB, "a5");
        wait_idle("a5");
        chk("a5_len16", done_edge[0] - acc_edge[0], 640 + 64 * PB);
        chk("a5_len32", done_edge[1] - acc_edge[1], 704 + 64 * PB);
        chk("a5_one_pulse", n_done[0] - d0, 1);

`ifdef UART_TX_PARITY_EN
        send_aligned(8'hA4);
        exp_bits = 16'h0748;
        sample_frame(exp_bits, 11, "a4");
        wait_idle("a4");
        chk("a4_len16", done_edge[0] - acc_edge[0], 704);
`endif

        // Request during DATA is ignored
        b0 = n_acc[0];
        send_aligned(8'h00);
        repeat (200) @(posedge clk);
        @(negedge clk);
        #1;
        din = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        #1;
        tx_start = 1'b0;
        din = 8'h33;
        wait_idle("ign");
        repeat (100) @(posedge clk);
        #2;
        chk("ign_frames", n_acc[0] - b0, 1);

        // Back-to-back with tx_start held high
        b0 = n_acc[0]; b1 = n_acc[1];
        d0 = n_done[0]; d1 = n_done[1];
        @(negedge clk);
        #1;
        din = 8'h55;
        tx_start = 1'b1;
        begin
            int n;
            n = 0;
            while (n_acc[0] < b0 + 1 && n < 6000) begin @(posedge clk); #2; n++; end
            din = 8'h0F;
            while ((n_acc[0] < b0 + 2 || n_acc[1] < b1 + 2) && n < 6000) begin
                @(posedge clk); #2; n++;
            end
            chk("b2b_timeout", (n >= 6000), 0);
        end
        tx_start = 1'b0;
        wait_idle("b2b");
        chk("b2b_gap16", gap[0], 1);
        chk("b2b_gap32", gap[1], 1);
        chk("b2b_done16", n_done[0] - d0, 2);
        chk("b2b_done32", n_done[1] - d1, 2);

        // Two stop bits on the 32-tick instance
        send_aligned(8'h81);
        wait_idle("stop32");
        chk("stop32_len", done_edge[1] - acc_edge[1], 704 + 64 * PB);

        // Reset mid-DATA abandons the frame
        send_aligned(8'h3C);
        repeat (300) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx16", o_tx[0], 1'b1);
        chk("mid_rst_busy16", o_busy[0], 1'b0);
        chk("mid_rst_tx32", o_tx[1], 1'b1);
        chk("mid_rst_busy32", o_busy[1], 1'b0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        send_aligned(8'h3C);
        wait_idle("post_rst");
        chk("post_rst_len16", done_edge[0] - acc_edge[0], 640 + 64 * PB);

        // Randomized frames, tick phases and stray requests
        for (int it = 0; it < 8; it++) begin
            wait_idle("rnd_idle");
            tick_period = $urandom_range(1, 5);
            repeat ($urandom_range(0, 7)) @(negedge clk);
            #1;
            din = DBIT'($urandom);
            tx_start = 1'b1;
            @(negedge clk);
            #1;
            tx_start = 1'b0;
            repeat ($urandom_range(10, 400)) @(negedge clk);
            #1;
            din = DBIT'($urandom);
            tx_start = 1'b1;
            @(negedge clk);
            #1;
            tx_start = 1'b0;
        end
        wait_idle("rnd_end");
        repeat (20) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART block. Takes a parallel word on a one-cycle start strobe and shifts it out LSB-first as an asynchronous serial frame: start bit, DBIT data bits, an optional parity bit, and a stop period. Bit timing comes from the shared baud-rate generator's 16x oversampling tick (`s_tick`). Sits between the TX FIFO read side and the `tx` pin.

## Interface
- `DBIT`, default 8: data bits per frame, legal 5–9.
- `SB_TICK`, default 16: stop period length in `s_tick` ticks; 16 = 1 stop bit, 24 = 1.5, 32 = 2.

Ports:
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `s_tick`  input  1  one-`clk`-wide enable from the baud generator, 16 per bit period.
- `tx_start`  input  1  request to send `din`; sampled only in IDLE.
- `din`  input  DBIT  word to transmit; captured on acceptance.
- `tx`  output  1  serial line, registered, idle high.
- `tx_busy`  output  1  high in every state except IDLE.
- `tx_done_tick`  output  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro defined), STOP.
- Registers: `s_reg` (4-bit tick count), `n_reg` (bit index, width clog2(DBIT)), `b_reg` (DBIT shift register), `tx_reg`.
- IDLE: `tx_reg` = 1. When `tx_start` = 1: load `b_reg` <= `din`, clear `s_reg`, go to START.
- START: `tx_reg` = 0. On each `s_tick`, increment `s_reg`. On the `s_tick` where `s_reg` = 15: clear `s_reg` and `n_reg`, go to DATA.
- DATA: `tx_reg` = `b_reg[0]`. On the `s_tick` where `s_reg` = 15:
  - shift `b_reg` right by 1;
  - if `n_reg` = DBIT-1, go to PARITY (or to STOP without the macro);
  - otherwise increment `n_reg`.
- STOP: `tx_reg` = 1. On the `s_tick` where `s_reg` = SB_TICK-1: assert `tx_done_tick` and go to IDLE. `s_reg` is widened internally to hold SB_TICK-1.
- `s_reg` only changes on `s_tick`. Cycles without `s_tick` hold all state.
- `tx_start` outside IDLE is ignored and not queued. `din` changes after acceptance have no effect.
- Reset mid-frame: on `rst_n` low, everything returns to IDLE at once and `tx` goes high. The partial frame is abandoned.

## Timing
- Reset values: `tx` = 1, `tx_busy` = 0, `tx_done_tick` = 0. State IDLE, all counters 0.
- Start latency: `tx_start` sampled at edge k drives `tx` low from edge k (registered output), independent of `s_tick` phase.
- Each start, data and parity bit lasts exactly 16 `s_tick` periods. STOP lasts SB_TICK periods.
- The first-bit duration depends on the `s_tick` phase at acceptance. It is 16 ticks counted from acceptance, so it can be up to one tick period short of later bits.
- `tx_done_tick` is high for exactly the one cycle after the final stop-tick edge, while the state is already IDLE. `tx_busy` is 0 in that same cycle.
- Back-to-back: `tx_start` is accepted in the same cycle `tx_done_tick` is high. The next start bit then follows the stop period with no idle gap.
- Frame length, in `s_tick` periods: 16·(1 + DBIT [+1 with parity]) + SB_TICK.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - adds the PARITY state after DATA for 16 ticks;
  - `tx` carries the even parity (XOR of all DBIT data bits of the captured word), computed at acceptance and held in a register.
- Undefined: no PARITY state; DATA goes straight to STOP.

## Test plan
- Reset: assert `rst_n` = 0 mid-DATA of a 0x3C frame → `tx` = 1, `tx_busy` = 0 immediately. The next frame after release transmits correctly.
- Single frame, DBIT = 8, SB_TICK = 16, `s_tick` every 4 `clk`, `din` = 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 `clk`. `tx_done_tick` is a single pulse 640 `clk` after acceptance.
- Ignored request: pulse `tx_start` with `din` = 0xFF during DATA of a 0x00 frame → frame still 0x00, no second frame follows.
- Back-to-back: hold `tx_start` high with 0x55 then 0x0F → two frames with no idle cycles between the stop bit and the next start bit, and two `tx_done_tick` pulses.
- Stop length: SB_TICK = 32, `din` = 0x81 → stop high for 128 `clk` (2 bits) before `tx_done_tick`.
- Parity (`UART_TX_PARITY_EN`): 0xA5 → parity bit 0. 0xA4 → parity bit 1. Frame grows to 11 bits (704 `clk`).
